mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage; sits directly downstream of the execute stage and consumes its results.
- Loads and stores go to a data memory over a req/gnt/rvalid handshake. Non-memory results pass through to writeback after one register.
- Stalls execute via o_mem_ready while an access is outstanding.
- Handles RV64 load/store sizing, byte-lane steering, sign/zero extension, misalignment and response timeout.

Parameters:
TIMEOUT, 256, max cycles in WAIT before abort; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
i_ex_valid  in  1  execute result valid
o_mem_ready  out  1  stage can accept (state==IDLE)
i_ex_alu_result  in  64  effective address (mem ops) or ALU result
i_ex_store_data  in  64  store operand (rs2)
i_ex_rd  in  5  destination register
i_ex_rd_we  in  1  destination write enable
i_ex_is_load  in  1  load op
i_ex_is_store  in  1  store op
i_ex_funct3  in  3  0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU
o_dmem_req  out  1  memory request
o_dmem_we  out  1  1 = write
o_dmem_addr  out  64  address, bits[2:0] forced to 0
o_dmem_be  out  8  byte enables
o_dmem_wdata  out  64  lane-steered store data
i_dmem_gnt  in  1  request accepted
i_dmem_rvalid  in  1  read data valid
i_dmem_rdata  in  64  read data
o_wb_valid  out  1  writeback valid, 1-cycle pulse
o_wb_rd  out  5  writeback register
o_wb_rd_we  out  1  writeback enable
o_wb_data  out  64  writeback data
o_mem_exc  out  1  exception pulse (misaligned, illegal or timeout), coincident with o_wb_valid

Behaviour:
- Reset: all outputs 0 except o_mem_ready=1; state IDLE; timeout counter 0.
- Reset mid-access: request dropped; a late rvalid after reset is ignored.
- FSM has three states: IDLE, REQ, WAIT. All outputs are registered.
- Accept: the edge where i_ex_valid && o_mem_ready; latch all i_ex_* fields.
- Non-memory op (neither is_load nor is_store):
  - Next cycle: o_wb_valid=1, o_wb_data=alu_result, rd and rd_we passed through.
  - Stay IDLE; back-to-back accepts give full throughput.
- Illegal op:
  - Conditions: is_load && is_store; funct3==7; store with funct3>=4.
  - Response: o_wb_valid=1, o_mem_exc=1, o_wb_rd_we=0; no dmem request; stay IDLE.
- Misaligned (addr not a multiple of size; size = 1<<funct3[1:0]): same response as illegal.
- Aligned mem op: go to REQ. o_dmem_req=1 from the cycle after accept and held, with addr/we/be/wdata stable, until sampled with i_dmem_gnt=1.
- Byte enables: o_dmem_be = size_mask << addr[2:0]; size_mask is 0x01, 0x03, 0x0F or 0xFF.
- Store data: o_dmem_wdata = store_data << (8*addr[2:0]).
- Store completion: at the gnt edge, req drops. Next cycle o_wb_valid=1 with rd_we=0, data 0; return to IDLE.
- Load completion:
  - At the gnt edge, req drops and the FSM enters WAIT. rvalid is sampled only in WAIT; rvalid in the same cycle as gnt is not accepted.
  - On rvalid: shifted = rdata >> (8*addr[2:0]), truncated to size.
  - Sign-extend for funct3 0–2; zero-extend for 3–6.
  - Next cycle o_wb_valid=1 with rd/rd_we and the extended data; return to IDLE.
- Minimum load latency: accept T, req T+1 (gnt in the same cycle), rvalid T+2, wb T+3. Minimum store latency: wb T+2.
- Timeout: counter increments each cycle in WAIT and clears on entry.
  - If TIMEOUT!=0 and the count reaches TIMEOUT with no rvalid: o_wb_valid=1, o_mem_exc=1, rd_we=0; return to IDLE.
  - rvalid and timeout in the same cycle: rvalid wins.
- o_mem_ready=0 in REQ and WAIT; i_ex_valid is ignored while not ready.

Test Plan:
- ALU pass-through: valid, alu_result=0x1234, rd=5, rd_we=1, three consecutive cycles -> three consecutive wb pulses, data 0x1234, rd 5; ready never drops.
- LB sign-extend: addr 0x1003, gnt immediate, rvalid next cycle, rdata 0x00000000_80000000 -> be=0x08, dmem_addr 0x1000, wb_data 0xFFFFFFFF_FFFFFF80 at T+3.
- SH lane steering: addr 0x2006, store_data 0xABCD, gnt delayed 3 cycles -> req held 4 cycles with be=0xC0, wdata 0xABCD0000_00000000; ready low throughout; wb pulse with rd_we=0.
- Misaligned LW: addr 0x3002 -> no req; next cycle wb_valid=1, mem_exc=1, rd_we=0.
- Timeout: TIMEOUT=4, LD granted, no rvalid -> mem_exc pulse after 4 WAIT cycles, back to IDLE. Then a late rvalid is ignored and a following LWU of 0xFFFFFFFF returns 0x00000000_FFFFFFFF.
- Reset in WAIT: rst for one cycle, then rvalid -> no wb pulse; outputs 0, ready=1.

Source files
------------

// File: rtl/mem_stage_if.sv
// Signal bundle between the execute stage, the memory stage, the data memory and writeback.
// The slave modport is the memory stage's view; the master modport is its environment's view.
interface mem_stage_if;
   logic        i_ex_valid;
   logic        o_mem_ready;
   logic [63:0] i_ex_alu_result;
   logic [63:0] i_ex_store_data;
   logic [4:0]  i_ex_rd;
   logic        i_ex_rd_we;
   logic        i_ex_is_load;
   logic        i_ex_is_store;
   logic [2:0]  i_ex_funct3;
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic [63:0] o_dmem_addr;
   logic [7:0]  o_dmem_be;
   logic [63:0] o_dmem_wdata;
   logic        i_dmem_gnt;
   logic        i_dmem_rvalid;
   logic [63:0] i_dmem_rdata;
   logic        o_wb_valid;
   logic [4:0]  o_wb_rd;
   logic        o_wb_rd_we;
   logic [63:0] o_wb_data;
   logic        o_mem_exc;

   modport slave (
      input  i_ex_valid, i_ex_alu_result, i_ex_store_data, i_ex_rd, i_ex_rd_we,
             i_ex_is_load, i_ex_is_store, i_ex_funct3,
             i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata,
      output o_mem_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
             o_wb_valid, o_wb_rd, o_wb_rd_we, o_wb_data, o_mem_exc
   );

   modport master (
      output i_ex_valid, i_ex_alu_result, i_ex_store_data, i_ex_rd, i_ex_rd_we,
             i_ex_is_load, i_ex_is_store, i_ex_funct3,
             i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata,
      input  o_mem_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
             o_wb_valid, o_wb_rd, o_wb_rd_we, o_wb_data, o_mem_exc
   );
endinterface

// File: rtl/mem_stage.sv
// RV64 memory-access stage: sizes and lane-steers loads/stores onto a req/gnt/rvalid data memory,
// extends load data, flags misaligned/illegal accesses and response timeouts; ALU results pass through.
module mem_stage #(
   parameter int unsigned TIMEOUT = 256
) (
   input logic        clk,
   input logic        rst,
   mem_stage_if.slave bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t      state, state_n;
   logic [31:0] cnt_q, cnt_n;

   logic        ready_q, ready_n;
   logic        req_q, req_n;
   logic        we_q, we_n;
   logic [63:0] addr_q, addr_n;
   logic [7:0]  be_q, be_n;
   logic [63:0] wdata_q, wdata_n;
   logic        wb_valid_q, wb_valid_n;
   logic [4:0]  wb_rd_q, wb_rd_n;
   logic        wb_rd_we_q, wb_rd_we_n;
   logic [63:0] wb_data_q, wb_data_n;
   logic        exc_q, exc_n;

   logic [2:0]  off_p1;
   logic [2:0]  f3_p1;
   logic [4:0]  rd_p1;
   logic        rd_we_p1;

   logic        accept;
   logic        is_mem;
   logic        bad_op;

   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'd0:    size_mask = 8'h01;
         2'd1:    size_mask = 8'h03;
         2'd2:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] sz);
      case (sz)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = lo[0];
         2'd2:    misaligned = |lo[1:0];
         default: misaligned = |lo;
      endcase
   endfunction

   function automatic logic illegal(input logic ld, input logic st, input logic [2:0] f3);
      illegal = (ld && st) || (f3 == 3'd7) || (st && f3[2]);
   endfunction

   // Raw is already shifted down so the addressed byte sits in bits [7:0].
   function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [2:0] f3);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] w;
      b = signed'(raw[7:0]);
      h = signed'(raw[15:0]);
      w = signed'(raw[31:0]);
      case (f3)
         3'd0:    load_extend = {{56{b[7]}}, b};
         3'd1:    load_extend = {{48{h[15]}}, h};
         3'd2:    load_extend = {{32{w[31]}}, w};
         3'd4:    load_extend = {56'd0, raw[7:0]};
         3'd5:    load_extend = {48'd0, raw[15:0]};
         3'd6:    load_extend = {32'd0, raw[31:0]};
         default: load_extend = raw;
      endcase
   endfunction

   assign accept = (state == IDLE) && bus.i_ex_valid;
   assign is_mem = bus.i_ex_is_load || bus.i_ex_is_store;
   assign bad_op = illegal(bus.i_ex_is_load, bus.i_ex_is_store, bus.i_ex_funct3) ||
                   misaligned(bus.i_ex_alu_result[2:0], bus.i_ex_funct3[1:0]);

   always_comb begin
      state_n    = state;
      cnt_n      = cnt_q;
      req_n      = req_q;
      we_n       = we_q;
      addr_n     = addr_q;
      be_n       = be_q;
      wdata_n    = wdata_q;
      wb_valid_n = 1'b0;
      wb_rd_n    = 5'd0;
      wb_rd_we_n = 1'b0;
      wb_data_n  = 64'd0;
      exc_n      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!is_mem) begin
                  wb_valid_n = 1'b1;
                  wb_rd_n    = bus.i_ex_rd;
                  wb_rd_we_n = bus.i_ex_rd_we;
                  wb_data_n  = bus.i_ex_alu_result;
               end else if (bad_op) begin
                  wb_valid_n = 1'b1;
                  wb_rd_n    = bus.i_ex_rd;
                  exc_n      = 1'b1;
               end else begin
                  state_n = REQ;
                  req_n   = 1'b1;
                  we_n    = bus.i_ex_is_store;
                  addr_n  = {bus.i_ex_alu_result[63:3], 3'b000};
                  be_n    = size_mask(bus.i_ex_funct3[1:0]) << bus.i_ex_alu_result[2:0];
                  wdata_n = bus.i_ex_store_data << {bus.i_ex_alu_result[2:0], 3'b000};
               end
            end
         end
         REQ: begin
            if (bus.i_dmem_gnt) begin
               req_n = 1'b0;
               if (we_q) begin
                  wb_valid_n = 1'b1;
                  wb_rd_n    = rd_p1;
                  state_n    = IDLE;
               end else begin
                  cnt_n   = 32'd0;
                  state_n = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_n = cnt_q + 32'd1;
            // A response arriving on the timeout cycle still completes the load normally.
            if (bus.i_dmem_rvalid) begin
               wb_valid_n = 1'b1;
               wb_rd_n    = rd_p1;
               wb_rd_we_n = rd_we_p1;
               wb_data_n  = load_extend(bus.i_dmem_rdata >> {off_p1, 3'b000}, f3_p1);
               state_n    = IDLE;
            end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT - 1)) begin
               wb_valid_n = 1'b1;
               wb_rd_n    = rd_p1;
               exc_n      = 1'b1;
               state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      ready_n = (state_n == IDLE);
   end

   // Stage boundary: control state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt_q      <= 32'd0;
         ready_q    <= 1'b1;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 64'd0;
         be_q       <= 8'd0;
         wdata_q    <= 64'd0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_rd_we_q <= 1'b0;
         wb_data_q  <= 64'd0;
         exc_q      <= 1'b0;
      end else begin
         state      <= state_n;
         cnt_q      <= cnt_n;
         ready_q    <= ready_n;
         req_q      <= req_n;
         we_q       <= we_n;
         addr_q     <= addr_n;
         be_q       <= be_n;
         wdata_q    <= wdata_n;
         wb_valid_q <= wb_valid_n;
         wb_rd_q    <= wb_rd_n;
         wb_rd_we_q <= wb_rd_we_n;
         wb_data_q  <= wb_data_n;
         exc_q      <= exc_n;
      end
   end

   // Stage boundary: operand fields captured at accept for use at completion
   always_ff @(posedge clk) begin
      if (accept) begin
         off_p1   <= bus.i_ex_alu_result[2:0];
         f3_p1    <= bus.i_ex_funct3;
         rd_p1    <= bus.i_ex_rd;
         rd_we_p1 <= bus.i_ex_rd_we;
      end
   end

   assign bus.o_mem_ready  = ready_q;
   assign bus.o_dmem_req   = req_q;
   assign bus.o_dmem_we    = we_q;
   assign bus.o_dmem_addr  = addr_q;
   assign bus.o_dmem_be    = be_q;
   assign bus.o_dmem_wdata = wdata_q;
   assign bus.o_wb_valid   = wb_valid_q;
   assign bus.o_wb_rd      = wb_rd_q;
   assign bus.o_wb_rd_we   = wb_rd_we_q;
   assign bus.o_wb_data    = wb_data_q;
   assign bus.o_mem_exc    = exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single transactions with hand-computed results,
// plus sequences for back-to-back ALU ops, delayed grant, timeout and reset during WAIT.
module tb_mem_stage;
   logic clk;
   logic rst;
   int   passed;
   int   total;

   mem_stage_if bus ();

   mem_stage #(.TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] alu;
      logic [63:0] sdata;
      logic [63:0] rdata;
      logic [4:0]  rd;
      logic        rd_we;
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic        req;
      logic [63:0] addr;
      logic [7:0]  be;
      logic [63:0] wdata;
      logic [63:0] wb_data;
      logic        wb_we;
      logic        exc;
   } vec_t;

   vec_t vecs [19];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive_op(input logic [63:0] alu, input logic [63:0] sdata, input logic [4:0] rd,
                           input logic rd_we, input logic ld, input logic st, input logic [2:0] f3);
      bus.i_ex_valid      = 1'b1;
      bus.i_ex_alu_result = alu;
      bus.i_ex_store_data = sdata;
      bus.i_ex_rd         = rd;
      bus.i_ex_rd_we      = rd_we;
      bus.i_ex_is_load    = ld;
      bus.i_ex_is_store   = st;
      bus.i_ex_funct3     = f3;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      @(negedge clk);
      drive_op(v.alu, v.sdata, v.rd, v.rd_we, v.ld, v.st, v.f3);
      @(negedge clk);
      bus.i_ex_valid = 1'b0;
      chk({nm, " req"}, 64'(bus.o_dmem_req), 64'(v.req));
      if (v.req) begin
         chk({nm, " ready"}, 64'(bus.o_mem_ready), 64'd0);
         chk({nm, " addr"}, bus.o_dmem_addr, v.addr);
         chk({nm, " be"}, 64'(bus.o_dmem_be), 64'(v.be));
         chk({nm, " we"}, 64'(bus.o_dmem_we), 64'(v.st));
         if (v.st) chk({nm, " wdata"}, bus.o_dmem_wdata, v.wdata);
         bus.i_dmem_gnt = 1'b1;
         @(negedge clk);
         bus.i_dmem_gnt = 1'b0;
         chk({nm, " req drop"}, 64'(bus.o_dmem_req), 64'd0);
         if (!v.st) begin
            chk({nm, " no early wb"}, 64'(bus.o_wb_valid), 64'd0);
            bus.i_dmem_rvalid = 1'b1;
            bus.i_dmem_rdata  = v.rdata;
            @(negedge clk);
            bus.i_dmem_rvalid = 1'b0;
         end
      end
      chk({nm, " wb_valid"}, 64'(bus.o_wb_valid), 64'd1);
      chk({nm, " exc"}, 64'(bus.o_mem_exc), 64'(v.exc));
      chk({nm, " wb_we"}, 64'(bus.o_wb_rd_we), 64'(v.wb_we));
      if (!v.exc) chk({nm, " wb_data"}, bus.o_wb_data, v.wb_data);
      if (!v.exc && !v.st) chk({nm, " wb_rd"}, 64'(bus.o_wb_rd), 64'(v.rd));
   endtask

   initial begin
      vec_t lwu;
      passed = 0;
      total  = 0;
      rst = 1'b1;
      bus.i_ex_valid = 1'b0; bus.i_ex_alu_result = '0; bus.i_ex_store_data = '0;
      bus.i_ex_rd = '0; bus.i_ex_rd_we = 1'b0; bus.i_ex_is_load = 1'b0;
      bus.i_ex_is_store = 1'b0; bus.i_ex_funct3 = '0;
      bus.i_dmem_gnt = 1'b0; bus.i_dmem_rvalid = 1'b0; bus.i_dmem_rdata = '0;

      //        alu                    sdata                  rdata                  rd     we ld st f3    req addr          be     wdata                  wb_data                wbwe exc
      vecs[0]  = '{64'h1234,           64'h0,                 64'h0,                 5'd5,  1, 0, 0, 3'd0, 0, 64'h0,       8'h00, 64'h0,                 64'h1234,              1, 0};
      vecs[1]  = '{64'h1003,           64'h0,                 64'h0000000080000000,  5'd6,  1, 1, 0, 3'd0, 1, 64'h1000,    8'h08, 64'h0,                 64'hFFFFFFFFFFFFFF80,  1, 0};
      vecs[2]  = '{64'h1003,           64'h0,                 64'h0000000080000000,  5'd7,  1, 1, 0, 3'd4, 1, 64'h1000,    8'h08, 64'h0,                 64'h0000000000000080,  1, 0};
      vecs[3]  = '{64'h1006,           64'h0,                 64'h8001000000000000,  5'd8,  1, 1, 0, 3'd1, 1, 64'h1000,    8'hC0, 64'h0,                 64'hFFFFFFFFFFFF8001,  1, 0};
      vecs[4]  = '{64'h1004,           64'h0,                 64'h89ABCDEF00000000,  5'd9,  1, 1, 0, 3'd2, 1, 64'h1000,    8'hF0, 64'h0,                 64'hFFFFFFFF89ABCDEF,  1, 0};
      vecs[5]  = '{64'h1004,           64'h0,                 64'h89ABCDEF00000000,  5'd10, 1, 1, 0, 3'd6, 1, 64'h1000,    8'hF0, 64'h0,                 64'h0000000089ABCDEF,  1, 0};
      vecs[6]  = '{64'h1008,           64'h0,                 64'h0123456789ABCDEF,  5'd11, 1, 1, 0, 3'd3, 1, 64'h1008,    8'hFF, 64'h0,                 64'h0123456789ABCDEF,  1, 0};
      vecs[7]  = '{64'h1002,           64'h0,                 64'h00000000FEDC0000,  5'd12, 1, 1, 0, 3'd5, 1, 64'h1000,    8'h0C, 64'h0,                 64'h000000000000FEDC,  1, 0};
      vecs[8]  = '{64'h2005,           64'h11223344556677AA,  64'h0,                 5'd13, 1, 0, 1, 3'd0, 1, 64'h2000,    8'h20, 64'h6677AA0000000000,  64'h0,                 0, 0};
      vecs[9]  = '{64'h2004,           64'h00000000DEADBEEF,  64'h0,                 5'd14, 1, 0, 1, 3'd2, 1, 64'h2000,    8'hF0, 64'hDEADBEEF00000000,  64'h0,                 0, 0};
      vecs[10] = '{64'h2000,           64'h0123456789ABCDEF,  64'h0,                 5'd15, 1, 0, 1, 3'd3, 1, 64'h2000,    8'hFF, 64'h0123456789ABCDEF,  64'h0,                 0, 0};
      vecs[11] = '{64'h2002,           64'h000000000000BEEF,  64'h0,                 5'd16, 1, 0, 1, 3'd1, 1, 64'h2000,    8'h0C, 64'h00000000BEEF0000,  64'h0,                 0, 0};
      vecs[12] = '{64'h3002,           64'h0,                 64'h0,                 5'd17, 1, 1, 0, 3'd2, 0, 64'h0,       8'h00, 64'h0,                 64'h0,                 0, 1};
      vecs[13] = '{64'h3000,           64'h0,                 64'h0,                 5'd18, 1, 1, 0, 3'd7, 0, 64'h0,       8'h00, 64'h0,                 64'h0,                 0, 1};
      vecs[14] = '{64'h3000,           64'h0,                 64'h0,                 5'd19, 1, 0, 1, 3'd4, 0, 64'h0,       8'h00, 64'h0,                 64'h0,                 0, 1};
      vecs[15] = '{64'h3000,           64'h0,                 64'h0,                 5'd20, 1, 1, 1, 3'd3, 0, 64'h0,       8'h00, 64'h0,                 64'h0,                 0, 1};
      vecs[16] = '{64'h2004,           64'h0,                 64'h0,                 5'd21, 1, 0, 1, 3'd3, 0, 64'h0,       8'h00, 64'h0,                 64'h0,                 0, 1};
      vecs[17] = '{64'h1001,           64'h0,                 64'h0,                 5'd22, 1, 1, 0, 3'd1, 0, 64'h0,       8'h00, 64'h0,                 64'h0,                 0, 1};
      vecs[18] = '{64'h1006,           64'h0,                 64'h0,                 5'd23, 1, 1, 0, 3'd6, 0, 64'h0,       8'h00, 64'h0,                 64'h0,                 0, 1};

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset ready", 64'(bus.o_mem_ready), 64'd1);
      chk("reset req", 64'(bus.o_dmem_req), 64'd0);
      chk("reset wb_valid", 64'(bus.o_wb_valid), 64'd0);
      chk("reset exc", 64'(bus.o_mem_exc), 64'd0);
      chk("reset addr", bus.o_dmem_addr, 64'd0);
      chk("reset wb_data", bus.o_wb_data, 64'd0);

      for (int i = 0; i < 19; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Three back-to-back ALU results
      @(negedge clk);
      drive_op(64'h1234, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 2) bus.i_ex_valid = 1'b0;
         chk($sformatf("b2b wb_valid%0d", i), 64'(bus.o_wb_valid), 64'd1);
         chk($sformatf("b2b data%0d", i), bus.o_wb_data, 64'h1234);
         chk($sformatf("b2b rd%0d", i), 64'(bus.o_wb_rd), 64'd5);
         chk($sformatf("b2b ready%0d", i), 64'(bus.o_mem_ready), 64'd1);
      end
      @(negedge clk);
      chk("b2b end", 64'(bus.o_wb_valid), 64'd0);

      // SH with grant delayed three cycles
      drive_op(64'h2006, 64'h000000000000ABCD, 5'd3, 1'b1, 1'b0, 1'b1, 3'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.i_ex_valid = 1'b0;
         chk($sformatf("sh req%0d", i), 64'(bus.o_dmem_req), 64'd1);
         chk($sformatf("sh be%0d", i), 64'(bus.o_dmem_be), 64'hC0);
         chk($sformatf("sh wdata%0d", i), bus.o_dmem_wdata, 64'hABCD000000000000);
         chk($sformatf("sh ready%0d", i), 64'(bus.o_mem_ready), 64'd0);
         chk($sformatf("sh wb_valid%0d", i), 64'(bus.o_wb_valid), 64'd0);
         if (i == 3) bus.i_dmem_gnt = 1'b1;
      end
      @(negedge clk);
      bus.i_dmem_gnt = 1'b0;
      chk("sh done wb_valid", 64'(bus.o_wb_valid), 64'd1);
      chk("sh done rd_we", 64'(bus.o_wb_rd_we), 64'd0);
      chk("sh done req", 64'(bus.o_dmem_req), 64'd0);
      @(negedge clk);
      chk("sh ready back", 64'(bus.o_mem_ready), 64'd1);

      // LD granted, never answered: timeout after four WAIT cycles
      drive_op(64'h4000, 64'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'd3);
      @(negedge clk);
      bus.i_ex_valid = 1'b0;
      chk("to req", 64'(bus.o_dmem_req), 64'd1);
      bus.i_dmem_gnt = 1'b1;
      @(negedge clk);
      bus.i_dmem_gnt = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      chk("to not yet", 64'(bus.o_wb_valid), 64'd0);
      chk("to ready low", 64'(bus.o_mem_ready), 64'd0);
      @(negedge clk);
      chk("to wb_valid", 64'(bus.o_wb_valid), 64'd1);
      chk("to exc", 64'(bus.o_mem_exc), 64'd1);
      chk("to rd_we", 64'(bus.o_wb_rd_we), 64'd0);
      chk("to ready", 64'(bus.o_mem_ready), 64'd1);
      bus.i_dmem_rvalid = 1'b1;
      bus.i_dmem_rdata  = 64'hDEADDEADDEADDEAD;
      @(negedge clk);
      bus.i_dmem_rvalid = 1'b0;
      chk("late rvalid", 64'(bus.o_wb_valid), 64'd0);
      chk("late exc", 64'(bus.o_mem_exc), 64'd0);
      lwu = '{64'h4000, 64'h0, 64'h00000000FFFFFFFF, 5'd9, 1, 1, 0, 3'd6, 1, 64'h4000, 8'h0F, 64'h0,
              64'h00000000FFFFFFFF, 1, 0};
      run_vec(lwu, "post-timeout lwu");

      // Reset while waiting for read data, then a stale rvalid
      @(negedge clk);
      drive_op(64'h5000, 64'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'd3);
      @(negedge clk);
      bus.i_ex_valid = 1'b0;
      bus.i_dmem_gnt = 1'b1;
      @(negedge clk);
      bus.i_dmem_gnt = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.i_dmem_rvalid = 1'b1;
      bus.i_dmem_rdata  = 64'h1111111111111111;
      chk("rst ready", 64'(bus.o_mem_ready), 64'd1);
      chk("rst req", 64'(bus.o_dmem_req), 64'd0);
      @(negedge clk);
      bus.i_dmem_rvalid = 1'b0;
      chk("rst stale wb", 64'(bus.o_wb_valid), 64'd0);
      chk("rst stale data", bus.o_wb_data, 64'd0);
      chk("rst addr", bus.o_dmem_addr, 64'd0);
      chk("rst be", 64'(bus.o_dmem_be), 64'd0);
      @(negedge clk);
      chk("rst idle wb", 64'(bus.o_wb_valid), 64'd0);
      chk("rst idle ready", 64'(bus.o_mem_ready), 64'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
